// File: rtl/activation_loader_if.sv
// Single-outstanding read port between the activation loader and system memory.
interface activation_loader_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/activation_loader.sv
// Fetches NUM_WORDS activation words from memory into the PIM activation buffer.
// Optional ACT_LOADER_STRIDE_EN adds a per-load byte stride input (default stride 4).
module activation_loader #(
   parameter int NUM_WORDS = 9,
   parameter int ADDR_W    = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [ADDR_W-1:0]  i_base_addr,
`ifdef ACT_LOADER_STRIDE_EN
   input  logic [15:0]        i_stride,
`endif
   output logic               o_idle,
   output logic               o_done,
   activation_loader_if.master mem,
   output logic               o_activation_buffer_busy,
   output logic               o_activation_in_en,
   output logic [7:0]         o_counter,
   output logic [31:0]        o_data,
   output logic               o_activation_out_en,
   input  logic               i_pim_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE,
      S_COMPUTE,
      S_DONE
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

   state_t            state_q, state_d;
   logic [7:0]        index_q, index_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        counter_q, counter_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] stride_w;

`ifdef ACT_LOADER_STRIDE_EN
   logic [15:0]       stride_q, stride_d;
   assign stride_w = ADDR_W'(stride_q);
`else
   assign stride_w = ADDR_W'(4);
`endif

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      addr_d    = addr_q;
      counter_d = counter_q;
      data_d    = data_q;
`ifdef ACT_LOADER_STRIDE_EN
      stride_d  = stride_q;
`endif
      // Abort wins over every handshake input in the same cycle.
      if (i_abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start && !i_abort) begin
                  state_d = S_REQ;
                  addr_d  = i_base_addr;
                  index_d = '0;
`ifdef ACT_LOADER_STRIDE_EN
                  stride_d = i_stride;
`endif
               end
            end
            S_REQ: begin
               if (mem.mem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (mem.mem_rvalid) begin
                  state_d   = S_WRITE;
                  counter_d = index_q;
                  data_d    = mem.mem_rdata;
               end
            end
            S_WRITE: begin
               if (index_q == LAST_IDX) begin
                  state_d = S_COMPUTE;
               end else begin
                  state_d = S_REQ;
                  index_d = index_q + 8'd1;
                  addr_d  = addr_q + stride_w;
               end
            end
            S_COMPUTE: begin
               if (i_pim_ack) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      // Buffer-facing index and data rest at zero whenever the loader is idle.
      if (state_d == S_IDLE) begin
         index_d   = '0;
         counter_d = '0;
         data_d    = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         addr_q    <= '0;
         counter_q <= '0;
         data_q    <= '0;
`ifdef ACT_LOADER_STRIDE_EN
         stride_q  <= 16'd4;
`endif
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         addr_q    <= addr_d;
         counter_q <= counter_d;
         data_q    <= data_d;
`ifdef ACT_LOADER_STRIDE_EN
         stride_q  <= stride_d;
`endif
      end
   end

   assign o_idle                   = (state_q == S_IDLE);
   assign o_done                   = (state_q == S_DONE);
   assign mem.mem_req              = (state_q == S_REQ);
   assign mem.mem_addr             = addr_q;
   assign o_activation_buffer_busy = (state_q == S_REQ) || (state_q == S_WAIT) ||
                                     (state_q == S_WRITE) || (state_q == S_COMPUTE);
   assign o_activation_in_en       = (state_q == S_WRITE);
   assign o_activation_out_en      = (state_q == S_COMPUTE);
   assign o_counter                = counter_q;
   assign o_data                   = data_q;

endmodule

// File: tb/tb_activation_loader.sv
// Directed, table-driven bench for activation_loader.
module tb_activation_loader;
   localparam int NW = 9;

   typedef struct {
      int          gdly;
      int          rdly;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [7:0]  exp_cnt;
      bit          noise;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort, pim_ack;
   logic [31:0] base;
   logic        idle, done, busy, in_en, out_en;
   logic [7:0]  counter;
   logic [31:0] data;
`ifdef ACT_LOADER_STRIDE_EN
   logic [15:0] stride;
`endif
   int n_chk  = 0;
   int n_pass = 0;
   vec_t vec [3*NW];

   activation_loader_if #(.ADDR_W(32)) mem ();

   activation_loader #(.NUM_WORDS(NW), .ADDR_W(32)) dut (
      .i_clk                    (clk),
      .i_rst                    (rst),
      .i_start                  (start),
      .i_abort                  (abort),
      .i_base_addr              (base),
`ifdef ACT_LOADER_STRIDE_EN
      .i_stride                 (stride),
`endif
      .o_idle                   (idle),
      .o_done                   (done),
      .mem                      (mem),
      .o_activation_buffer_busy (busy),
      .o_activation_in_en       (in_en),
      .o_counter                (counter),
      .o_data                   (data),
      .o_activation_out_en      (out_en),
      .i_pim_ack                (pim_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered with the DUT in REQ for this word; leaves it in the following state.
   task automatic do_word(input vec_t v);
      chk("req", 32'(mem.mem_req), 1);
      chk("addr", mem.mem_addr, v.exp_addr);
      for (int c = 0; c < v.gdly; c++) begin
         if (v.noise) begin start = 1'b1; pim_ack = 1'b1; end
         tick();
         start = 1'b0; pim_ack = 1'b0;
         chk("req_hold", 32'(mem.mem_req), 1);
         chk("addr_hold", mem.mem_addr, v.exp_addr);
      end
      mem.mem_gnt = 1'b1;
      if (v.noise) begin mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hDEAD_0000; end
      tick();
      mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
      chk("wait_req", 32'(mem.mem_req), 0);
      chk("wait_in_en", 32'(in_en), 0);
      for (int c = 0; c < v.rdly; c++) begin
         tick();
         chk("wait_hold_in_en", 32'(in_en), 0);
      end
      mem.mem_rvalid = 1'b1; mem.mem_rdata = v.rdata;
      tick();
      mem.mem_rvalid = 1'b0;
      chk("in_en", 32'(in_en), 1);
      chk("counter", 32'(counter), 32'(v.exp_cnt));
      chk("data", data, v.rdata);
      chk("busy_w", 32'(busy), 1);
      tick();
      chk("in_en_single", 32'(in_en), 0);
      chk("counter_held", 32'(counter), 32'(v.exp_cnt));
   endtask

   task automatic do_load(input int first, input logic [31:0] b);
      base = b; start = 1'b1;
      tick();
      start = 1'b0;
      chk("idle_after_start", 32'(idle), 0);
      chk("busy_after_start", 32'(busy), 1);
      for (int i = 0; i < NW; i++) do_word(vec[first + i]);
   endtask

   task automatic compute_phase(input bit noise);
      chk("out_en", 32'(out_en), 1);
      chk("busy_c", 32'(busy), 1);
      if (noise) start = 1'b1;
      tick();
      start = 1'b0;
      chk("out_en_hold", 32'(out_en), 1);
      chk("done_early", 32'(done), 0);
      pim_ack = 1'b1;
      tick();
      pim_ack = 1'b0;
      chk("done", 32'(done), 1);
      chk("busy_done", 32'(busy), 0);
      chk("out_en_done", 32'(out_en), 0);
      tick();
      chk("done_pulse", 32'(done), 0);
      chk("idle_end", 32'(idle), 1);
      chk("counter_idle", 32'(counter), 0);
      chk("data_idle", data, 0);
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin
         vec[i]        = '{1, 0, 32'(32'hA0 + i), 32'(32'h1000 + 4*i), 8'(i), 1'b0};
         vec[NW + i]   = '{1, 0, 32'(32'hB0 + i), 32'(32'h1000 + 4*i), 8'(i), 1'b0};
         vec[2*NW + i] = '{1, 0, 32'(32'hC0 + i), 32'(32'h2000 + 4*i), 8'(i), 1'b0};
      end
      vec[NW + 4].gdly    = 3;
      vec[NW + 4].rdly    = 5;
      vec[2*NW].gdly      = 2;
      vec[2*NW].noise     = 1'b1;

      rst = 1'b1; start = 1'b0; abort = 1'b0; pim_ack = 1'b0; base = '0;
      mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
`ifdef ACT_LOADER_STRIDE_EN
      stride = 16'd4;
`endif
      #3;
      chk("rst_idle", 32'(idle), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req", 32'(mem.mem_req), 0);
      chk("rst_addr", mem.mem_addr, 0);
      chk("rst_counter", 32'(counter), 0);
      chk("rst_data", data, 0);
      chk("rst_out_en", 32'(out_en), 0);
      #9 rst = 1'b0;
      tick();

      // Basic load, backpressured load, load with spurious start/ack/rvalid.
      do_load(0, 32'h1000);
      compute_phase(1'b0);
      do_load(NW, 32'h1000);
      compute_phase(1'b0);
      do_load(2*NW, 32'h2000);
      compute_phase(1'b1);

      // Abort while waiting for word 2's read data.
      base = 32'h1000; start = 1'b1;
      tick();
      start = 1'b0;
      do_word(vec[0]);
      do_word(vec[1]);
      chk("ab_addr", mem.mem_addr, 32'h1008);
      tick();
      mem.mem_gnt = 1'b1;
      tick();
      mem.mem_gnt = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_idle", 32'(idle), 1);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_done", 32'(done), 0);
      mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem.mem_rvalid = 1'b0;
      chk("late_rv_in_en", 32'(in_en), 0);
      chk("late_rv_idle", 32'(idle), 1);
      chk("late_rv_data", data, 0);
      chk("late_rv_done", 32'(done), 0);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'(idle), 1);

      // Restart from word 0, then async reset while in COMPUTE.
      do_load(0, 32'h1000);
      chk("pre_rst_out_en", 32'(out_en), 1);
      #3 rst = 1'b1;
      #1;
      chk("arst_idle", 32'(idle), 1);
      chk("arst_out_en", 32'(out_en), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_counter", 32'(counter), 0);
      chk("arst_data", data, 0);
      chk("arst_addr", mem.mem_addr, 0);
      chk("arst_done", 32'(done), 0);
      #1 rst = 1'b0;
      tick();
      chk("post_rst_idle", 32'(idle), 1);

`ifdef ACT_LOADER_STRIDE_EN
      begin
         vec_t v;
         base = 32'hFFFF_FFF0; stride = 16'd8; start = 1'b1;
         tick();
         start = 1'b0; stride = 16'd4;
         for (int i = 0; i < 3; i++) begin
            v = '{1, 0, 32'(32'hE0 + i), 32'(32'hFFFF_FFF0 + 8*i), 8'(i), 1'b0};
            do_word(v);
         end
         abort = 1'b1;
         tick();
         abort = 1'b0;
         chk("stride_abort_idle", 32'(idle), 1);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
